// File: rtl/de2_qsys_oci_dct_pkg.sv
// Shared constants and state type for the OCI compressed-trace packer.
package de2_qsys_oci_dct_pkg;

  localparam int DCT_SYM_W = 2;
  localparam int DCT_DEPTH = 15;
  localparam int DCT_BUF_W = DCT_SYM_W * DCT_DEPTH;
  localparam int DCT_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_FLUSH = 1'b1
  } dct_pack_state_t;

endpackage : de2_qsys_oci_dct_pkg

// File: rtl/de2_qsys_oci_dct_frame_reg.sv
// Output holding register for packed trace frames.
// Holds a frame stable while the consumer stalls and reports when it can
// accept a new frame on the coming edge.
module de2_qsys_oci_dct_frame_reg
  import de2_qsys_oci_dct_pkg::*;
#(
  parameter int BUF_W = DCT_BUF_W,
  parameter int CNT_W = DCT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [BUF_W-1:0] buf_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [BUF_W-1:0] buf_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Free when empty, or when the current frame is taken on this edge.
  assign free_o = !valid_q || ready_i;

  // Next-state: load a new frame, retire a taken frame, or hold.
  always_comb begin
    valid_d = valid_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      valid_d = 1'b1;
      buf_d   = buf_i;
      cnt_d   = cnt_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Frame register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      buf_q   <= {BUF_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign buf_o   = buf_q;
  assign cnt_o   = cnt_q;

endmodule : de2_qsys_oci_dct_frame_reg

// File: rtl/de2_qsys_cpu_oci_dct_packer.sv
// Packs 2-bit compressed trace symbols into 30-bit frames (oldest symbol
// highest) and hands them downstream; a flush drains a partial frame.
module de2_qsys_cpu_oci_dct_packer
  import de2_qsys_oci_dct_pkg::*;
#(
  parameter int SYM_W = DCT_SYM_W,
  parameter int DEPTH = DCT_DEPTH,
  parameter int CNT_W = DCT_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sym_valid,
  input  logic [SYM_W-1:0]       sym,
  output logic                   sym_ready,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   dct_valid,
  output logic [SYM_W*DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  input  logic                   dct_ready
);

  localparam int BUF_W = SYM_W * DEPTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  dct_pack_state_t  state_q, state_d;
  logic [BUF_W-1:0] acc_buf_q, acc_buf_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             flush_done_q, flush_done_d;
  logic             xfer_s;
  logic             accept_s;
  logic             ready_s;
  logic             out_free_s;

  de2_qsys_oci_dct_frame_reg #(
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_frame_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (xfer_s),
    .buf_i   (acc_buf_q),
    .cnt_i   (acc_cnt_q),
    .ready_i (dct_ready),
    .valid_o (dct_valid),
    .buf_o   (dct_buffer),
    .cnt_o   (dct_count),
    .free_o  (out_free_s)
  );

  // FSM next state, symbol acceptance, frame transfer and accumulator update.
  // ready_s never depends on sym_valid.
  always_comb begin
    state_d      = state_q;
    acc_buf_d    = acc_buf_q;
    acc_cnt_d    = acc_cnt_q;
    flush_done_d = 1'b0;
    xfer_s       = 1'b0;
    ready_s      = 1'b0;
    case (state_q)
      ST_FILL: begin
        ready_s = (acc_cnt_q < FULL_CNT) || out_free_s;
        xfer_s  = (acc_cnt_q == FULL_CNT) && out_free_s;
        if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FLUSH: begin
        ready_s = 1'b0;
        if (acc_cnt_q == ZERO_CNT) begin
          flush_done_d = 1'b1;
          state_d      = ST_FILL;
        end else if (out_free_s) begin
          xfer_s       = 1'b1;
          flush_done_d = 1'b1;
          state_d      = ST_FILL;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    accept_s = sym_valid && ready_s;

    // A transfer empties the accumulator; a symbol taken on the same edge
    // starts the next frame.
    if (xfer_s) begin
      if (accept_s) begin
        acc_buf_d = {{(BUF_W-SYM_W){1'b0}}, sym};
        acc_cnt_d = ONE_CNT;
      end else begin
        acc_buf_d = {BUF_W{1'b0}};
        acc_cnt_d = ZERO_CNT;
      end
    end else if (accept_s) begin
      acc_buf_d = {acc_buf_q[BUF_W-SYM_W-1:0], sym};
      acc_cnt_d = acc_cnt_q + ONE_CNT;
    end else begin
      acc_buf_d = acc_buf_q;
      acc_cnt_d = acc_cnt_q;
    end
  end

  // State, accumulator and flush-done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      acc_buf_q    <= {BUF_W{1'b0}};
      acc_cnt_q    <= ZERO_CNT;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_buf_q    <= acc_buf_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign sym_ready  = ready_s;
  assign flush_done = flush_done_q;

endmodule : de2_qsys_cpu_oci_dct_packer

// File: tb/tb_de2_qsys_cpu_oci_dct_packer.sv
// Self-checking bench: queue-based frame model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_de2_qsys_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym = 2'd0;
  logic        sym_ready;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  de2_qsys_cpu_oci_dct_packer dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .sym_ready  (sym_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .dct_valid  (dct_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .dct_ready  (dct_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          acc_q[$];
  logic        m_valid = 1'b0;
  logic [29:0] m_buf = 30'd0;
  logic [3:0]  m_cnt = 4'd0;
  bit          m_flush = 1'b0;
  bit          m_done = 1'b0;
  bit          m_on = 1'b0;

  always @(posedge clk) begin : model
    bit free, rdy, take, emit, done;
    logic [29:0] p;
    if (reset) begin
      acc_q.delete();
      m_valid = 1'b0; m_buf = 30'd0; m_cnt = 4'd0;
      m_flush = 1'b0; m_done = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      free = !m_valid || dct_ready;
      rdy  = !m_flush && (acc_q.size() < 15 || free);
      take = sym_valid && rdy;
      emit = 1'b0;
      done = 1'b0;
      if (!m_flush) emit = (acc_q.size() == 15) && free;
      else if (acc_q.size() == 0) done = 1'b1;
      else if (free) begin emit = 1'b1; done = 1'b1; end
      if (emit) begin
        p = 30'd0;
        foreach (acc_q[i]) p = p * 30'd4 + 30'(acc_q[i]);
        m_buf = p;
        m_cnt = 4'(acc_q.size());
        m_valid = 1'b1;
        acc_q.delete();
      end else if (m_valid && dct_ready) begin
        m_valid = 1'b0;
      end
      if (take) acc_q.push_back(int'(sym));
      if (!m_flush) m_flush = flush;
      else if (done) m_flush = 1'b0;
      m_done = done;
    end
  end

  always @(posedge clk) begin : hs_counter
    if (!reset && dct_valid && dct_ready) hs_cnt++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : compare
    bit exp_rdy;
    if (m_on && !reset) begin
      exp_rdy = !m_flush && (acc_q.size() < 15 || !m_valid || dct_ready);
      chk("sym_ready", 32'(sym_ready), 32'(exp_rdy));
      chk("dct_valid", 32'(dct_valid), 32'(m_valid));
      chk("flush_done", 32'(flush_done), 32'(m_done));
      if (m_valid) begin
        chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
        chk("dct_count", 32'(dct_count), 32'(m_cnt));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    sym_valid = 1'b1;
    sym = s;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit got;
    got = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (flush_done) got = 1'b1;
      tick();
    end
    chk("flush_seen", 32'(got), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(dct_valid), 32'd0);
    chk({tag, "_buf"}, 32'(dct_buffer), 32'd0);
    chk({tag, "_cnt"}, 32'(dct_count), 32'd0);
    chk({tag, "_done"}, 32'(flush_done), 32'd0);
    chk({tag, "_ready"}, 32'(sym_ready), 32'd1);
  endtask

  initial begin
    int n_acc;
    int low;
    int h0;
    logic [1:0] abcde [5];
    abcde[0] = 2'd3; abcde[1] = 2'd2; abcde[2] = 2'd1; abcde[3] = 2'd0; abcde[4] = 2'd3;

    // Reset
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk_reset_vals("rst");

    // A: 15 x 01 -> 0x15555555, visible one cycle after the 15th accept
    dct_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_sym(2'b01);
    @(negedge clk);
    chk("a_early_valid", 32'(dct_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("a_valid", 32'(dct_valid), 32'd1);
    chk("a_buf", 32'(dct_buffer), 32'h15555555);
    chk("a_cnt", 32'(dct_count), 32'd15);
    tick();

    // B: 3,2,1,0,3 then flush -> count 5, buffer 0x393
    for (int i = 0; i < 5; i++) send_sym(abcde[i]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("b_done_early", 32'(flush_done), 32'd0);
    tick();
    @(negedge clk);
    chk("b_valid", 32'(dct_valid), 32'd1);
    chk("b_done", 32'(flush_done), 32'd1);
    chk("b_cnt", 32'(dct_count), 32'd5);
    chk("b_buf", 32'(dct_buffer), 32'h393);
    tick();
    tick();

    // C: flush with empty accumulator
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("c_done_early", 32'(flush_done), 32'd0);
    tick();
    @(negedge clk);
    chk("c_done", 32'(flush_done), 32'd1);
    chk("c_valid", 32'(dct_valid), 32'd0);
    tick();

    // D: back-pressure while streaming 40 symbols
    dct_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      sym_valid = 1'b1;
      sym = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (sym_ready) n_acc++;
      tick();
    end
    chk("d_accepted", 32'(n_acc), 32'd30);
    @(negedge clk);
    chk("d_ready_low", 32'(sym_ready), 32'd0);
    dct_ready = 1'b1;
    for (int i = 0; i < 60 && n_acc < 40; i++) begin
      sym = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (sym_ready) n_acc++;
      tick();
    end
    sym_valid = 1'b0;
    chk("d_all_accepted", 32'(n_acc), 32'd40);
    do_flush();

    // E: continuous 45 symbols with dct_ready high
    tick();
    h0 = hs_cnt;
    low = 0;
    for (int i = 0; i < 45; i++) begin
      sym_valid = 1'b1;
      sym = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (!sym_ready) low++;
      tick();
    end
    sym_valid = 1'b0;
    repeat (3) tick();
    chk("e_ready_low", 32'(low), 32'd0);
    chk("e_frames", 32'(hs_cnt - h0), 32'd3);

    // F: reset after 7 symbols and a pending flush
    dct_ready = 1'b0;
    for (int i = 0; i < 7; i++) send_sym(2'($urandom_range(0, 3)));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("f");
    dct_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_sym(2'b10);
    tick();
    @(negedge clk);
    chk("f_valid", 32'(dct_valid), 32'd1);
    chk("f_buf", 32'(dct_buffer), 32'h2AAAAAAA);
    chk("f_cnt", 32'(dct_count), 32'd15);
    tick();

    // G: randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      sym_valid = ($urandom_range(0, 3) != 0);
      sym = 2'($urandom_range(0, 3));
      dct_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    sym_valid = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
    dct_ready = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_de2_qsys_cpu_oci_dct_packer
